// File: rtl/shared_tlb_arb_pkg.sv
// Shared types for the shared-TLB arbiter: FSM states, requester IDs, per-grant context.
package shared_tlb_arb_pkg;

  // Context storage widths; the top-level VPN_W/ASID_W must not exceed these.
  localparam int CTX_VPN_W  = 27;
  localparam int CTX_ASID_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    PTW_REQ  = 3'd2,
    PTW_WAIT = 3'd3,
    RESP     = 3'd4,
    DRAIN    = 3'd5
  } arb_state_e;

  typedef enum logic {
    SRC_DTLB = 1'b0,
    SRC_ITLB = 1'b1
  } req_src_e;

  typedef struct packed {
    logic [CTX_VPN_W-1:0]  vpn;
    logic [CTX_ASID_W-1:0] asid;
    req_src_e              src;
  } arb_ctx_t;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter: req_i[0]=DTLB, req_i[1]=ITLB; pointer moves only on a grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = ITLB won the last grant, so DTLB is favoured out of reset
  logic r_last;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = r_last ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        r_last <= 1'b1;
    else if (|gnt_o)  r_last <= gnt_o[1];
  end

endmodule

// File: rtl/shared_tlb_arbiter.sv
// Sequences ITLB/DTLB misses through the shared L2 TLB and the PTW.
// Optional perf counters: define SHARED_TLB_ARB_PERF_EN.
module shared_tlb_arbiter
  import shared_tlb_arb_pkg::*;
#(
  parameter int VPN_W  = 27,
  parameter int ASID_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              itlb_req_i,
  input  logic [VPN_W-1:0]  itlb_vpn_i,
  output logic              itlb_ack_o,
  input  logic              dtlb_req_i,
  input  logic [VPN_W-1:0]  dtlb_vpn_i,
  output logic              dtlb_ack_o,
  output logic              resp_valid_o,
  output logic              resp_is_instr_o,
  output logic              resp_hit_o,
  output logic              stlb_req_o,
  output logic [VPN_W-1:0]  stlb_vpn_o,
  output logic [ASID_W-1:0] stlb_asid_o,
  input  logic              stlb_valid_i,
  input  logic              stlb_hit_i,
  output logic              ptw_req_o,
  output logic              ptw_is_instr_o,
  input  logic              ptw_ready_i,
  input  logic              ptw_done_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  perf_hit_cnt_o,
  output logic [CNT_W-1:0]  perf_miss_cnt_o
);

  arb_state_e r_state, w_state_nxt;
  arb_ctx_t   r_ctx;
  logic       r_hit, r_iack, r_dack, r_stlb_req;
  logic [1:0] w_gnt;
  logic       w_grant, w_lookup_done, w_resp_valid, w_ptw_req;

  rr_arb2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  ((r_state == IDLE) && !flush_i),
    .req_i ({itlb_req_i, dtlb_req_i}),
    .gnt_o (w_gnt)
  );

  assign w_grant       = |w_gnt;
  assign w_lookup_done = (r_state == LOOKUP) && stlb_valid_i && !flush_i;
  assign w_resp_valid  = (r_state == RESP) && !flush_i;
  assign w_ptw_req     = (r_state == PTW_REQ) && !flush_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_grant) w_state_nxt = LOOKUP;
      LOOKUP:   if (flush_i) w_state_nxt = IDLE;
                else if (stlb_valid_i) w_state_nxt = stlb_hit_i ? RESP : PTW_REQ;
      PTW_REQ:  if (flush_i) w_state_nxt = IDLE;
                else if (ptw_ready_i) w_state_nxt = PTW_WAIT;
      // a walk finishing in the flush cycle has nothing left to drain
      PTW_WAIT: if (flush_i) w_state_nxt = ptw_done_i ? IDLE : DRAIN;
                else if (ptw_done_i) w_state_nxt = RESP;
      RESP:     w_state_nxt = IDLE;
      DRAIN:    if (ptw_done_i) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ctx      <= '0;
      r_hit      <= 1'b0;
      r_iack     <= 1'b0;
      r_dack     <= 1'b0;
      r_stlb_req <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_iack     <= w_gnt[1];
      r_dack     <= w_gnt[0];
      r_stlb_req <= w_grant;
      if (w_grant) begin
        r_ctx.vpn  <= w_gnt[1] ? CTX_VPN_W'(itlb_vpn_i) : CTX_VPN_W'(dtlb_vpn_i);
        r_ctx.asid <= CTX_ASID_W'(asid_i);
        r_ctx.src  <= w_gnt[1] ? SRC_ITLB : SRC_DTLB;
      end
      if (w_lookup_done) r_hit <= stlb_hit_i;
    end
  end

  assign itlb_ack_o      = r_iack;
  assign dtlb_ack_o      = r_dack;
  assign stlb_req_o      = r_stlb_req;
  assign stlb_vpn_o      = VPN_W'(r_ctx.vpn);
  assign stlb_asid_o     = ASID_W'(r_ctx.asid);
  assign resp_valid_o    = w_resp_valid;
  assign resp_hit_o      = w_resp_valid && r_hit;
  assign resp_is_instr_o = w_resp_valid && (r_ctx.src == SRC_ITLB);
  assign ptw_req_o       = w_ptw_req;
  assign ptw_is_instr_o  = w_ptw_req && (r_ctx.src == SRC_ITLB);
  assign busy_o          = (r_state != IDLE);

`ifdef SHARED_TLB_ARB_PERF_EN
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  // flush does not clear the counters; a flushed lookup is not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_lookup_done) begin
      if (stlb_hit_i) r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      else            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign perf_hit_cnt_o  = r_hit_cnt;
  assign perf_miss_cnt_o = r_miss_cnt;
`else
  assign perf_hit_cnt_o  = '0;
  assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_shared_tlb_arbiter.sv
// Directed bench for shared_tlb_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_shared_tlb_arbiter;
  localparam int VPN_W = 27, ASID_W = 16, CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, ireq, dreq, sv, sh, prdy, pdone;
  logic [VPN_W-1:0]  ivpn, dvpn;
  logic [ASID_W-1:0] asid;
  logic iack, dack, rv, rinstr, rhit, sreq, preq, pinstr, busy;
  logic [VPN_W-1:0]  svpn;
  logic [ASID_W-1:0] sasid;
  logic [CNT_W-1:0]  phit, pmiss;

  shared_tlb_arbiter #(.VPN_W(VPN_W), .ASID_W(ASID_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .asid_i(asid),
    .itlb_req_i(ireq), .itlb_vpn_i(ivpn), .itlb_ack_o(iack),
    .dtlb_req_i(dreq), .dtlb_vpn_i(dvpn), .dtlb_ack_o(dack),
    .resp_valid_o(rv), .resp_is_instr_o(rinstr), .resp_hit_o(rhit),
    .stlb_req_o(sreq), .stlb_vpn_o(svpn), .stlb_asid_o(sasid),
    .stlb_valid_i(sv), .stlb_hit_i(sh),
    .ptw_req_o(preq), .ptw_is_instr_o(pinstr), .ptw_ready_i(prdy), .ptw_done_i(pdone),
    .busy_o(busy), .perf_hit_cnt_o(phit), .perf_miss_cnt_o(pmiss)
  );

  int nvec = 0, nerr = 0;

  // exp bits: {iack, dack, resp_valid, resp_is_instr, resp_hit, stlb_req, ptw_req, busy}
  typedef struct {
    string      name;
    logic       rst, flush, ireq, dreq, sv, sh, prdy, pdone;
    logic [26:0] ivpn, dvpn;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string n, input logic r, f, ir, dr, v, h, pr, pd,
                     input logic [26:0] iv, dv, input logic [7:0] e);
    vec_t x;
    x.name = n; x.rst = r; x.flush = f; x.ireq = ir; x.dreq = dr; x.sv = v; x.sh = h;
    x.prdy = pr; x.pdone = pd; x.ivpn = iv; x.dvpn = dv; x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {iack, dack, rv, rinstr, rhit, sreq, preq, busy};
  endfunction

  task automatic clr_inputs();
    rst = 0; flush = 0; ireq = 0; dreq = 0; sv = 0; sh = 0; prdy = 0; pdone = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // DTLB transaction: hit completes with a response, miss is flushed in PTW_REQ
  task automatic do_txn(input logic hit);
    logic got;
    dreq = 1; dvpn = 27'h0000321; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = dack; if (!got) nxt(); end
    chk("txn_ack", got, 1);
    nxt(); dreq = 0; sv = 1; sh = hit;
    nxt(); sv = 0; sh = 0;
    if (hit) begin
      @(negedge clk); chk("txn_resp", rv, 1);
    end else begin
      flush = 1; @(negedge clk); chk("txn_flush_preq", preq, 0);
      nxt(); flush = 0;
    end
    nxt();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic got;
    int nreq, nresp, rk, badi;
    logic rh, ri;
    logic [15:0] busyv;
    logic [CNT_W-1:0] eh, em;

    clr_inputs(); rst = 1; ivpn = '0; dvpn = '0; asid = 16'h0055;
    // test 1: single DTLB hit, 3-cycle latency
    add("t1_idle",    0,0,0,0,0,0,0,0, 27'h0, 27'h1234, 8'b00000000);
    add("t1_req",     0,0,0,1,0,0,0,0, 27'h0, 27'h1234, 8'b00000000);
    add("t1_ack",     0,0,0,1,0,0,0,0, 27'h0, 27'h1234, 8'b01000101);
    add("t1_lookup",  0,0,0,0,1,1,0,0, 27'h0, 27'h1234, 8'b00000001);
    add("t1_resp",    0,0,0,0,0,0,0,0, 27'h0, 27'h1234, 8'b00101001);
    add("t1_back",    0,0,0,0,0,0,0,0, 27'h0, 27'h1234, 8'b00000000);
    // test 2: simultaneous requests after reset, DTLB first
    add("t2_rst",     1,0,0,0,0,0,0,0, 27'h0, 27'h0, 8'b00000000);
    add("t2_both",    0,0,1,1,0,0,0,0, 27'h111, 27'h222, 8'b00000000);
    add("t2_dgrant",  0,0,1,1,0,0,0,0, 27'h111, 27'h222, 8'b01000101);
    add("t2_dlookup", 0,0,1,0,1,1,0,0, 27'h111, 27'h222, 8'b00000001);
    add("t2_dresp",   0,0,1,0,0,0,0,0, 27'h111, 27'h222, 8'b00101001);
    add("t2_idle",    0,0,1,0,0,0,0,0, 27'h111, 27'h222, 8'b00000000);
    add("t2_igrant",  0,0,1,0,0,0,0,0, 27'h111, 27'h222, 8'b10000101);
    add("t2_imiss",   0,0,0,0,1,0,0,0, 27'h111, 27'h222, 8'b00000001);
    add("t2_ptwreq",  0,0,0,0,0,0,0,0, 27'h111, 27'h222, 8'b00000011);
    // test 4: flush in PTW_REQ masks ptw_req the same cycle
    add("t4_flush",   0,1,0,0,0,0,0,0, 27'h111, 27'h222, 8'b00000001);
    add("t4_idle",    0,0,0,0,0,0,0,0, 27'h111, 27'h222, 8'b00000000);
    add("t4_noresp",  0,0,0,0,0,0,0,0, 27'h111, 27'h222, 8'b00000000);
    // flush in IDLE blocks the grant; flush in LOOKUP aborts; stray stlb_valid ignored
    add("fi_block",   0,1,0,1,0,0,0,0, 27'h0, 27'hABC, 8'b00000000);
    add("fi_req",     0,0,0,1,0,0,0,0, 27'h0, 27'hABC, 8'b00000000);
    add("fi_grant",   0,0,0,1,0,0,0,0, 27'h0, 27'hABC, 8'b01000101);
    add("fl_lookup",  0,1,0,0,1,1,0,0, 27'h0, 27'hABC, 8'b00000001);
    add("fl_idle",    0,0,0,0,1,1,0,0, 27'h0, 27'hABC, 8'b00000000);
    add("fl_noresp",  0,0,0,0,0,0,0,0, 27'h0, 27'hABC, 8'b00000000);

    nxt(); nxt(); rst = 0;
    @(negedge clk);
    chk("rst_vpn", svpn, 0); chk("rst_asid", sasid, 0);
    chk("rst_phit", phit, 0); chk("rst_pmiss", pmiss, 0); chk("rst_pinstr", pinstr, 0);

    foreach (tbl[i]) begin
      nxt();
      rst = tbl[i].rst; flush = tbl[i].flush; ireq = tbl[i].ireq; dreq = tbl[i].dreq;
      sv = tbl[i].sv; sh = tbl[i].sh; prdy = tbl[i].prdy; pdone = tbl[i].pdone;
      ivpn = tbl[i].ivpn; dvpn = tbl[i].dvpn;
      @(negedge clk);
      chk(tbl[i].name, outs(), tbl[i].exp);
    end
    chk("held_vpn", svpn, 27'hABC); chk("held_asid", sasid, 16'h0055);

    // test 3: ITLB miss, ready in 4th request cycle, done 6 cycles later
    nxt(); clr_inputs(); ireq = 1; ivpn = 27'h7FFFFFF; asid = 16'hBEEF; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = iack; if (!got) nxt(); end
    chk("t3_ack", got, 1); chk("t3_vpn", svpn, 27'h7FFFFFF); chk("t3_asid", sasid, 16'hBEEF);
    nxt(); ireq = 0; sv = 1; sh = 0;
    nxt(); sv = 0;
    nreq = 0; nresp = 0; rk = -1; badi = 0; rh = 1'bx; ri = 1'bx;
    for (int k = 0; k < 15; k++) begin
      prdy = (k == 3); pdone = (k == 9);
      @(negedge clk);
      if (preq) begin nreq++; if (!pinstr) badi++; end
      if (rv) begin nresp++; rk = k; rh = rhit; ri = rinstr; end
      nxt();
    end
    prdy = 0; pdone = 0;
    chk("t3_ptw_cycles", nreq, 4); chk("t3_ptw_instr", badi, 0);
    chk("t3_nresp", nresp, 1); chk("t3_resp_cycle", rk, 10);
    chk("t3_resp_hit", rh, 0); chk("t3_resp_instr", ri, 1);

    // test 5: flush in PTW_WAIT drains until done, no response
    dreq = 1; dvpn = 27'h2468; asid = 16'h0055; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = dack; if (!got) nxt(); end
    chk("t5_ack", got, 1);
    nxt(); dreq = 0; sv = 1; sh = 0;
    nxt(); sv = 0;
    nresp = 0; busyv = '0;
    for (int k = 0; k < 10; k++) begin
      prdy = (k == 0); flush = (k == 2); pdone = (k == 6);
      @(negedge clk);
      busyv[k] = busy;
      if (rv) nresp++;
      nxt();
    end
    clr_inputs();
    chk("t5_busy", busyv, 16'h007F); chk("t5_nresp", nresp, 0);
    dreq = 1; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin @(negedge clk); got = dack; if (!got) nxt(); end
    chk("t5_regrant", got, 1);
    nxt(); dreq = 0; sv = 1; sh = 1;
    nxt(); sv = 0; sh = 0;
    @(negedge clk); chk("t5_resp", {rv, rhit, rinstr}, 3'b110);
    nxt();

    // test 6: perf counters (tied to 0 without the macro)
    rst = 1; nxt(); rst = 0;
    do_txn(1); do_txn(0); do_txn(1); do_txn(0); do_txn(1);
`ifdef SHARED_TLB_ARB_PERF_EN
    eh = 3; em = 2;
`else
    eh = 0; em = 0;
`endif
    @(negedge clk); chk("t6_hit", phit, eh); chk("t6_miss", pmiss, em);
    nxt(); flush = 1; nxt(); flush = 0;
    @(negedge clk); chk("t6_flush_hit", phit, eh); chk("t6_flush_miss", pmiss, em);
    nxt(); rst = 1; nxt(); rst = 0;
    @(negedge clk); chk("t6_rst_hit", phit, 0); chk("t6_rst_miss", pmiss, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
